// File: rtl/psk_pkg.sv
// Shared constants, FSM state type and phase arithmetic for the PSK symbol decoder.
package psk_pkg;

    localparam int NUM_PHASES = 6;
    localparam int PHASE_W    = 3;

    localparam logic [PHASE_W-1:0] DELTA_ZERO = 3'd0;
    localparam logic [PHASE_W-1:0] DELTA_PI   = 3'd3;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } psk_state_e;

    // Phase step (phase - prev) mod NUM_PHASES, kept within PHASE_W bits.
    function automatic logic [PHASE_W-1:0] phase_delta(
        input logic [PHASE_W-1:0] phase,
        input logic [PHASE_W-1:0] prev
    );
        logic [PHASE_W-1:0] d;
        if (phase >= prev) begin
            d = phase - prev;
        end else begin
            d = phase + PHASE_W'(NUM_PHASES) - prev;
        end
        return d;
    endfunction

    // Only a zero or half-circle step carries data.
    function automatic logic delta_is_legal(input logic [PHASE_W-1:0] d);
        return (d == DELTA_ZERO) || (d == DELTA_PI);
    endfunction

endpackage

// File: rtl/psk_phase_enc.sv
// Lowest-set-bit encoder turning the correlator phase-match bitmap into a
// carrier phase index; an empty bitmap is reported as an erasure.
module psk_phase_enc
    import psk_pkg::*;
(
    input  logic [NUM_PHASES-1:0] mask,
    output logic [PHASE_W-1:0]    phase,
    output logic                  erasure
);

    // Priority encode: the lowest matching phase wins when several fire.
    always_comb begin
        phase   = 3'd0;
        erasure = 1'b0;
        casez (mask)
            6'b?????1: phase = 3'd0;
            6'b????10: phase = 3'd1;
            6'b???100: phase = 3'd2;
            6'b??1000: phase = 3'd3;
            6'b?10000: phase = 3'd4;
            6'b100000: phase = 3'd5;
            default: begin
                phase   = 3'd0;
                erasure = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/psk_symbol_decoder.sv
// Differential 6-PSK symbol decoder: phase resolve, sync-word hunt, byte framing
// and a one-entry valid/ready hold buffer. Define PSK_DEC_ERRCNT_EN to add err_count.
module psk_symbol_decoder
    import psk_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD = 8'hD3,
    parameter int unsigned MAX_ERR   = 3
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [7:0] match_mask,
    input  logic       match_stb,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       overflow
`ifdef PSK_DEC_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int               ERR_W   = $clog2(MAX_ERR + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(MAX_ERR);

    psk_state_e         state_r;
    psk_state_e         state_nxt_s;
    logic [PHASE_W-1:0] prev_phase_r;
    logic [7:0]         shift_r;
    logic [2:0]         bit_cnt_r;
    logic [2:0]         bit_cnt_nxt_s;
    logic [ERR_W-1:0]   err_run_r;
    logic [ERR_W-1:0]   err_run_sat_s;
    logic [7:0]         byte_data_r;
    logic               byte_valid_r;
    logic               overflow_r;

    logic [PHASE_W-1:0] phase_s;
    logic               erasure_s;
    logic [PHASE_W-1:0] delta_s;
    logic               legal_s;
    logic               sym_bit_s;
    logic               good_s;
    logic               bad_s;
    logic [7:0]         shift_nxt_s;
    logic               byte_done_s;
    logic               load_s;
    logic               drop_s;
    logic               mask_unused_s;

    assign mask_unused_s = ^match_mask[7:6];

    psk_phase_enc u_phase_enc (
        .mask    (match_mask[NUM_PHASES-1:0]),
        .phase   (phase_s),
        .erasure (erasure_s)
    );

    // Classify the current symbol and form the candidate shift/error values.
    always_comb begin
        delta_s     = phase_delta(phase_s, prev_phase_r);
        sym_bit_s   = (delta_s == DELTA_PI);
        legal_s     = !erasure_s && delta_is_legal(delta_s);
        good_s      = match_stb && legal_s;
        bad_s       = match_stb && !legal_s;
        shift_nxt_s = {shift_r[6:0], sym_bit_s};
        if (err_run_r == ERR_MAX) begin
            err_run_sat_s = ERR_MAX;
        end else begin
            err_run_sat_s = err_run_r + ERR_W'(1);
        end
    end

    // Framer next-state: sync hunt, bit counting and loss of lock.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        byte_done_s   = 1'b0;
        case (state_r)
            HUNT: begin
                if (good_s && (shift_nxt_s == SYNC_WORD)) begin
                    state_nxt_s   = LOCK;
                    bit_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            LOCK: begin
                if (good_s) begin
                    bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    byte_done_s   = (bit_cnt_r == 3'd7);
                end else if (bad_s && (err_run_sat_s == ERR_MAX)) begin
                    state_nxt_s   = HUNT;
                    bit_cnt_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = LOCK;
                end
            end
            default: begin
                state_nxt_s   = HUNT;
                bit_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // A finished byte loads if the buffer is free or being drained right now.
    always_comb begin
        load_s = byte_done_s && (!byte_valid_r || byte_ready);
        drop_s = byte_done_s && !load_s;
    end

    // Symbol tracking: reference phase, bit window and consecutive-error run.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            prev_phase_r <= 3'd0;
            shift_r      <= 8'h00;
            err_run_r    <= {ERR_W{1'b0}};
        end else begin
            if (match_stb && !erasure_s) begin
                prev_phase_r <= phase_s;
            end
            if (good_s) begin
                shift_r   <= shift_nxt_s;
                err_run_r <= {ERR_W{1'b0}};
            end else if (bad_s) begin
                err_run_r <= err_run_sat_s;
            end
        end
    end

    // Framer state and bit counter.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_r   <= HUNT;
            bit_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    // Output hold buffer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            byte_data_r  <= 8'h00;
            byte_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            if (load_s) begin
                byte_data_r  <= shift_nxt_s;
                byte_valid_r <= 1'b1;
            end else if (byte_valid_r && byte_ready) begin
                byte_valid_r <= 1'b0;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef PSK_DEC_ERRCNT_EN
    logic [15:0] err_count_r;

    // Saturating count of every bad symbol, in either framer state.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            err_count_r <= 16'h0000;
        end else if (bad_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'h0001;
        end
    end

    assign err_count = err_count_r;
`endif

    assign byte_data  = byte_data_r;
    assign byte_valid = byte_valid_r;
    assign overflow   = overflow_r;
    assign locked     = (state_r == LOCK);

endmodule

// File: tb/tb_psk_symbol_decoder.sv
// Scoreboard bench for psk_symbol_decoder: directed scenarios plus random symbol
// streams checked against a procedural model of the decoding rules.
module tb_psk_symbol_decoder;

    localparam logic [7:0] SYNC = 8'hD3;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [7:0] match_mask;
    logic       match_stb;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       locked;
    logic       overflow;
`ifdef PSK_DEC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    psk_symbol_decoder dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .match_mask (match_mask),
        .match_stb  (match_stb),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .locked     (locked),
        .overflow   (overflow)
`ifdef PSK_DEC_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    // reference model state
    int         m_prev;
    logic [7:0] m_win;
    bit         m_locked;
    int         m_cnt;
    int         m_err_run;
    bit         m_full;
    bit         m_ovf;
    int         m_errcnt;
    logic [7:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit gaps_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(bit rst, bit stb, logic [7:0] mask, bit rdy);
        int ph;
        int d;
        bit good;
        bit b;
        bit load;
        bit acc;
        if (rst) begin
            m_prev = 0; m_win = 8'h00; m_locked = 0; m_cnt = 0; m_err_run = 0;
            m_full = 0; m_ovf = 0; m_errcnt = 0;
            exp_q.delete();
            return;
        end
        acc  = m_full && rdy;
        load = 0;
        if (stb) begin
            ph = -1;
            for (int i = 5; i >= 0; i--) if (mask[i]) ph = i;
            good = 0;
            b    = 0;
            if (ph >= 0) begin
                d      = (ph - m_prev + 6) % 6;
                m_prev = ph;
                good   = (d == 0) || (d == 3);
                b      = (d == 3);
            end
            if (good) begin
                m_win     = {m_win[6:0], b};
                m_err_run = 0;
                if (!m_locked) begin
                    if (m_win == SYNC) begin
                        m_locked = 1;
                        m_cnt    = 0;
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        if (!m_full || rdy) begin
                            exp_q.push_back(m_win);
                            load = 1;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
            end else begin
                if (m_errcnt < 65535) m_errcnt++;
                if (m_err_run < 3) m_err_run++;
                if (m_locked && m_err_run == 3) begin
                    m_locked = 0;
                    m_cnt    = 0;
                end
            end
        end
        if (load) m_full = 1;
        else if (acc) m_full = 0;
    endtask

    task automatic cycle(bit rst, bit stb, logic [7:0] mask, bit rdy);
        rst_in     = rst;
        match_stb  = stb;
        match_mask = mask;
        byte_ready = rdy;
        model_step(rst, stb, mask, rdy);
        @(posedge clk);
        #1;
        check("locked", {31'd0, locked}, {31'd0, m_locked});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("byte_valid", {31'd0, byte_valid}, {31'd0, m_full});
`ifdef PSK_DEC_ERRCNT_EN
        check("err_count", {16'd0, err_count}, m_errcnt);
`endif
    endtask

    function automatic logic [7:0] build_mask(int ph);
        logic [7:0] m;
        m = 8'h00;
        m[ph] = 1'b1;
        for (int j = ph + 1; j < 6; j++) if ($urandom_range(0, 3) == 0) m[j] = 1'b1;
        m[7:6] = 2'($urandom_range(0, 3));
        return m;
    endfunction

    task automatic idle(int n, bit rdy);
        for (int k = 0; k < n; k++) cycle(0, 0, 8'($urandom), rdy);
    endtask

    task automatic send_bit(bit b, bit rdy);
        int ph;
        if (gaps_en && $urandom_range(0, 3) == 0) idle(1, rdy);
        ph = (m_prev + (b ? 3 : 0)) % 6;
        cycle(0, 1, build_mask(ph), rdy);
    endtask

    task automatic send_bits(logic [7:0] v, int n, bit rdy);
        for (int i = 7; i > 7 - n; i--) send_bit(v[i], rdy);
    endtask

    task automatic do_reset();
        cycle(1, 1, 8'($urandom), 1'($urandom));
        cycle(1, 1, 8'($urandom), 1'($urandom));
    endtask

    // Monitor: any presented byte must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_in !== 1'b1 && byte_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL byte_data: byte %02h presented, none expected", byte_data);
            end else begin
                check("byte_data", {24'd0, byte_data}, {24'd0, exp_q[0]});
                if (byte_ready === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_in = 1'b1; match_stb = 1'b0; match_mask = 8'h00; byte_ready = 1'b0;

        // reset with strobes active, then idle
        do_reset();
        idle(1, 0);
        check("reset byte_data", {24'd0, byte_data}, 32'h0);

        // sync acquire then a data byte
        send_bits(SYNC, 8, 0);
        check("sync locked", {31'd0, locked}, 32'h1);
        send_bits(8'hA5, 8, 0);
        check("first byte", {24'd0, byte_data}, 32'hA5);
        idle(2, 1);

        // single erasure inside a byte keeps lock
        send_bits(8'h3C, 4, 1);
        cycle(0, 1, 8'h00, 1);
        send_bits(8'h3C << 4, 4, 1);
        idle(2, 1);

        // backpressure across two bytes
        send_bits(8'h5A, 8, 0);
        send_bits(8'h81, 8, 0);
        check("bp held byte", {24'd0, byte_data}, 32'h5A);
        check("bp overflow", {31'd0, overflow}, 32'h1);
        idle(1, 1);
        check("bp drained", {31'd0, byte_valid}, 32'h0);

        // reset in the middle of a byte with a byte buffered
        send_bits(8'h42, 8, 0);
        send_bits(8'h77, 4, 0);
        do_reset();
        check("midreset data", {24'd0, byte_data}, 32'h0);
        check("midreset valid", {31'd0, byte_valid}, 32'h0);

        // simultaneous accept and load
        send_bits(SYNC, 8, 0);
        send_bits(8'h11, 8, 0);
        send_bits(8'h22, 7, 0);
        send_bit(1'b0, 1);
        check("accload valid", {31'd0, byte_valid}, 32'h1);
        check("accload data", {24'd0, byte_data}, 32'h22);
        check("accload ovf", {31'd0, overflow}, 32'h0);
        idle(1, 1);

        // two erasures plus an illegal step drop lock
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, 8'h00, 1);
        cycle(0, 1, build_mask((m_prev + 1) % 6), 1);
        check("lock lost", {31'd0, locked}, 32'h0);

        // wrap and multi-bit masks while hunting: sync on the {2,5} phase pair
        cycle(0, 1, 8'hC0, 1);
        cycle(0, 1, 8'h20, 1);
        cycle(0, 1, 8'h04, 1);
        cycle(0, 1, 8'h20, 1);
        cycle(0, 1, 8'hE0, 1);
        cycle(0, 1, 8'h0C, 1);
        cycle(0, 1, 8'h04, 1);
        cycle(0, 1, 8'h34, 1);
        cycle(0, 1, 8'h20, 1);
        cycle(0, 1, 8'h04, 1);
        check("wrap relock", {31'd0, locked}, 32'h1);
        cycle(0, 1, 8'h06, 1);
        send_bits(8'hB7, 3, 1);
        cycle(0, 1, 8'hC0, 1);
        send_bits(8'hB7 << 3, 5, 1);
        idle(2, 1);

        // random streams
        gaps_en = 1'b1;
        for (int it = 0; it < 200; it++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 10) begin
                send_bits(SYNC, 8, 1'($urandom_range(0, 3) != 0));
            end else if (r < 28) begin
                logic [7:0] v;
                v = 8'($urandom);
                for (int i = 7; i >= 0; i--) send_bit(v[i], 1'($urandom_range(0, 3) != 0));
            end else if (r < 33) begin
                for (int k = 0; k < $urandom_range(1, 4); k++)
                    cycle(0, 1, 8'($urandom) & (($urandom_range(0, 2) == 0) ? 8'hC0 : 8'hFF), 1'($urandom));
            end else if (r < 36) begin
                idle($urandom_range(1, 3), 1'($urandom));
            end else if (r < 39) begin
                for (int k = 0; k < 3; k++) cycle(0, 1, 8'h00, 1'($urandom));
            end else begin
                do_reset();
            end
        end

        idle(4, 1);
        check("queue drained", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
